// File: rtl/sdc_bram_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : sdc_bram_stream_reader_if
// Description : Output stream bundle of the sector-buffer reader.
//               master : stream producer (the reader)
//               slave  : stream consumer (host FIFO / DMA engine)
//   dout        DATA_W  stream data, valid while dout_valid=1
//   dout_valid  1       word available on dout
//   dout_ready  1       consumer accepts the word at the next rising edge
// Revision    : 1.0  initial release
// ============================================================================
interface sdc_bram_stream_reader_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface
`default_nettype wire

// File: rtl/sdc_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : sdc_bram_stream_reader
// Description : Drains a block of words from the read port of the dual-port
//               sector buffer BRAM and presents them as a valid/ready stream.
//               A 4-entry prefetch FIFO hides the BRAM's 1-cycle registered
//               read latency, so the stream sustains one word per clock.
// Optional    : define SDC_RD_XOR_CHK_EN to build the running XOR checksum
//               on chk; otherwise chk is tied to zero.
// Ports       :
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        pulse; samples start_addr / word_cnt when idle
//   start_addr   first BRAM word to read
//   word_cnt     words to read, 1..2**ADDR_W (larger values are clamped)
//   abort        pulse; terminates the transfer without done
//   ram_addr     registered BRAM read address
//   ram_dataout  BRAM read data, valid one clock after ram_addr
//   strm         output stream (dout / dout_valid / dout_ready)
//   busy         transfer in progress
//   done         one-clock pulse after the final word is accepted
//   chk          XOR checksum of accepted words (or 0)
// Revision    : 1.0  initial release
// ============================================================================
module sdc_bram_stream_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [CNT_W-1:0]         word_cnt,
  input  logic                     abort,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [DATA_W-1:0]        ram_dataout,
  sdc_bram_stream_reader_if.master strm,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        chk
);

  localparam logic [CNT_W-1:0] c_max_len = CNT_W'(2**ADDR_W);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Transfer bookkeeping
  logic [ADDR_W-1:0] r_next_addr;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_accepted;
  logic [CNT_W-1:0]  w_len_in;

  // Inflight tags: r_v1 = address on ram_addr, r_v2 = data on ram_dataout
  logic r_v1;
  logic r_v2;

  // Prefetch FIFO
  logic [DATA_W-1:0] r_mem [4];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_occ;
  logic              r_done;

  logic       w_push;
  logic       w_pop;
  logic [3:0] w_load;
  logic       w_space_ok;
  logic       w_last_acc;
  logic       w_start_ok;
  logic       w_issue;
  logic       w_flush;
  logic       w_done_nxt;

  assign strm.dout       = r_mem[r_rd_ptr];
  assign strm.dout_valid = (r_occ != 3'd0);
  assign busy            = (r_state != S_IDLE);
  assign done            = r_done;

  assign w_len_in   = (word_cnt > c_max_len) ? c_max_len : word_cnt;
  assign w_push     = r_v2;
  assign w_pop      = strm.dout_valid && strm.dout_ready;
  // Words the FIFO must still absorb after this edge, counting both
  // inflight stages; a new issue is allowed only if it still fits.
  assign w_load     = {1'b0, r_occ} + {3'b0, r_v1} + {3'b0, r_v2} - {3'b0, w_pop};
  assign w_space_ok = (w_load < 4'd4);
  assign w_last_acc = w_pop && (r_accepted == (r_len - c_one));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_issue     = 1'b0;
    w_flush     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // abort in the same clock suppresses start
        if (start && !abort && (word_cnt != '0)) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if ((r_issued < r_len) && w_space_ok) begin
          w_issue = 1'b1;
          if (r_issued == (r_len - c_one)) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The final accept implies the FIFO and pipeline are empty.
        if (abort) begin
          w_flush     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_last_acc) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr    <= '0;
      r_next_addr <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_accepted  <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_occ       <= 3'd0;
      r_done      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_done <= w_done_nxt;

      if (w_start_ok) begin
        r_next_addr <= start_addr;
        r_len       <= w_len_in;
        r_issued    <= '0;
        r_accepted  <= '0;
      end

      // ram_addr only moves on an issue, so it holds while idle
      if (w_issue) begin
        ram_addr    <= r_next_addr;
        r_next_addr <= r_next_addr + ADDR_W'(1);
        r_issued    <= r_issued + c_one;
      end

      if (w_flush) begin
        r_v1     <= 1'b0;
        r_v2     <= 1'b0;
        r_wr_ptr <= 2'd0;
        r_rd_ptr <= 2'd0;
        r_occ    <= 3'd0;
      end else begin
        r_v2 <= r_v1;
        r_v1 <= w_issue;
        if (w_push) begin
          r_mem[r_wr_ptr] <= ram_dataout;
          r_wr_ptr        <= r_wr_ptr + 2'd1;
        end
        if (w_pop) begin
          r_rd_ptr   <= r_rd_ptr + 2'd1;
          r_accepted <= r_accepted + c_one;
        end
        r_occ <= r_occ + {2'b0, w_push} - {2'b0, w_pop};
      end
    end
  end

  // ---------------------------------------------------------- checksum
`ifdef SDC_RD_XOR_CHK_EN
  logic [DATA_W-1:0] r_chk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chk <= '0;
    end else if (w_start_ok) begin
      r_chk <= '0;
    end else if (w_pop) begin
      r_chk <= r_chk ^ strm.dout;
    end
  end

  assign chk = r_chk;
`else
  assign chk = '0;
`endif

endmodule
`default_nettype wire
